// File: rtl/sram_pkg.sv
// Shared constants for the DE2 SRAM arbiter: widths, port indices, FSM states.
package sram_pkg;
  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  localparam int P0 = 0;
  localparam int P1 = 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  // Active-low byte lanes: reads always enable both bytes.
  function automatic logic [1:0] lane_n(
    input logic       we,
    input logic [1:0] be
  );
    return we ? ~be : 2'b00;
  endfunction
endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle for the two SRAM ports.
interface sram_arbiter_if;
  import sram_pkg::*;

  logic               req0;
  logic               req1;
  logic               we0;
  logic               we1;
  logic [SRAM_AW-1:0] addr0;
  logic [SRAM_AW-1:0] addr1;
  logic [SRAM_DW-1:0] wdata0;
  logic [SRAM_DW-1:0] wdata1;
  logic [1:0]         be0;
  logic [1:0]         be1;
  logic               gnt0;
  logic               gnt1;
  logic               rvalid0;
  logic               rvalid1;
  logic [SRAM_DW-1:0] rdata;
  logic               busy;

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output be0, be1,
    input  gnt0, gnt1, rvalid0, rvalid1,
    input  rdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  be0, be1,
    output gnt0, gnt1, rvalid0, rvalid1,
    output rdata, busy
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin arbiter; the port not granted last wins a tie.
module sram_rr_arbiter
  import sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_last;

  always_comb begin
    grant     = 2'b00;
    grant[P0] = req[P0] & (~req[P1] | r_last);
    grant[P1] = req[P1] & (~req[P0] | ~r_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (advance && |req) begin
      r_last <= grant[P1];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the asynchronous 256Kx16 SRAM between two requesters with
// fixed-length SETUP/ACCESS/HOLD cycles and fully registered pin strobes.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int AW          = SRAM_AW,
  parameter int DW          = SRAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus,
  inout  wire  [DW-1:0] SRAM_DQ,
  output logic [AW-1:0] SRAM_ADDR,
  output logic          SRAM_CE_N,
  output logic          SRAM_OE_N,
  output logic          SRAM_WE_N,
  output logic          SRAM_UB_N,
  output logic          SRAM_LB_N
);

  localparam logic [2:0] WC = 3'(WAIT_CYCLES);

  logic [1:0]    r_state;
  logic [2:0]    r_cnt;
  logic          r_we;
  logic          r_port;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_dq_oe;
  logic          r_busy;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_rv0;
  logic          r_rv1;

  logic [1:0]    w_req;
  logic [1:0]    w_grant;
  logic          w_adv;
  logic          w_sel1;
  logic          w_we;
  logic [1:0]    w_lane;

  assign w_req  = {bus.req1, bus.req0};
  assign w_adv  = (r_state == S_IDLE);
  assign w_sel1 = w_grant[P1];
  assign w_we   = w_sel1 ? bus.we1 : bus.we0;
  assign w_lane = lane_n(w_we, w_sel1 ? bus.be1 : bus.be0);

  sram_rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (w_adv),
    .grant   (w_grant)
  );

  assign SRAM_DQ     = r_dq_oe ? r_wdata : {DW{1'bz}};
  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.rvalid0 = r_rv0;
  assign bus.rvalid1 = r_rv1;
  assign bus.rdata   = r_rdata;
  assign bus.busy    = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_we      <= 1'b0;
      r_port    <= 1'b0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_dq_oe   <= 1'b0;
      r_busy    <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rv0     <= 1'b0;
      r_rv1     <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_rv0  <= 1'b0;
      r_rv1  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|w_req) begin
            r_state   <= S_SETUP;
            r_busy    <= 1'b1;
            r_port    <= w_sel1;
            r_we      <= w_we;
            r_gnt0    <= w_grant[P0];
            r_gnt1    <= w_grant[P1];
            r_wdata   <= w_sel1 ? bus.wdata1 : bus.wdata0;
            r_dq_oe   <= w_we;
            SRAM_ADDR <= w_sel1 ? bus.addr1 : bus.addr0;
            SRAM_CE_N <= 1'b0;
            SRAM_OE_N <= w_we;
            SRAM_UB_N <= w_lane[1];
            SRAM_LB_N <= w_lane[0];
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_cnt     <= WC;
          SRAM_WE_N <= ~r_we;
        end
        S_ACCESS: begin
          if (r_cnt == 3'd0) begin
            r_state   <= S_HOLD;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            if (!r_we) r_rdata <= SRAM_DQ;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_HOLD: begin
          // Bus released here gives a full idle cycle before the next OE_N.
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_dq_oe   <= 1'b0;
          SRAM_CE_N <= 1'b1;
          SRAM_UB_N <= 1'b1;
          SRAM_LB_N <= 1'b1;
          r_rv0     <= ~r_we & ~r_port;
          r_rv1     <= ~r_we & r_port;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a behavioural SRAM.
module tb_sram_arbiter;
  import sram_pkg::*;

  logic clk;
  logic rst;

  sram_arbiter_if bus();
  sram_arbiter_if bus3();

  wire  [15:0] dq_a;
  logic [17:0] addr_a;
  logic        ce_a, oe_a, we_a, ub_a, lb_a;
  wire  [15:0] dq_b;
  logic [17:0] addr_b;
  logic        ce_b, oe_b, we_b, ub_b, lb_b;

  logic [15:0] mem_a [256] = '{default: 16'h0000};
  logic [15:0] mem_b [256] = '{default: 16'h0000};

  sram_arbiter #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .SRAM_DQ(dq_a), .SRAM_ADDR(addr_a),
    .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a), .SRAM_WE_N(we_a),
    .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a)
  );

  sram_arbiter #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .SRAM_DQ(dq_b), .SRAM_ADDR(addr_b),
    .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b), .SRAM_WE_N(we_b),
    .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b)
  );

  assign dq_a = (!ce_a && !oe_a && we_a) ? mem_a[addr_a[7:0]] : 16'hzzzz;
  assign dq_b = (!ce_b && !oe_b && we_b) ? mem_b[addr_b[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce_a && !we_a) begin
      if (!ub_a) mem_a[addr_a[7:0]][15:8] <= dq_a[15:8];
      if (!lb_a) mem_a[addr_a[7:0]][7:0]  <= dq_a[7:0];
    end
    if (!ce_b && !we_b) begin
      if (!ub_b) mem_b[addr_b[7:0]][15:8] <= dq_b[15:8];
      if (!lb_b) mem_b[addr_b[7:0]][7:0]  <= dq_b[7:0];
    end
  end

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int oe_lo [2];
  int we_lo [2];
  int bsy_n [2];
  int drv   [2];
  int drv_x [2];
  logic [15:0] wd [2];
  logic        wr [2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic samp(input int k, input logic oe, input logic we,
                      input logic bsy, input logic [15:0] dq);
    if (!oe) oe_lo[k]++;
    if (!we) we_lo[k]++;
    if (bsy) bsy_n[k]++;
    if (wr[k] && oe && dq === wd[k]) begin
      drv[k]++;
      if (!bsy) drv_x[k]++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    samp(0, oe_a, we_a, bus.busy, dq_a);
    samp(1, oe_b, we_b, bus3.busy, dq_b);
  endtask

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      oe_lo[k] = 0; we_lo[k] = 0; bsy_n[k] = 0;
      drv[k] = 0; drv_x[k] = 0;
    end
  endtask

  task automatic set_port(input int k, input bit p, input bit rq,
                          input bit we, input logic [17:0] a,
                          input logic [15:0] d, input logic [1:0] be);
    if (k == 1) begin
      bus3.req0 = rq; bus3.we0 = we; bus3.addr0 = a;
      bus3.wdata0 = d; bus3.be0 = be;
    end else if (!p) begin
      bus.req0 = rq; bus.we0 = we; bus.addr0 = a;
      bus.wdata0 = d; bus.be0 = be;
    end else begin
      bus.req1 = rq; bus.we1 = we; bus.addr1 = a;
      bus.wdata1 = d; bus.be1 = be;
    end
  endtask

  function automatic logic g_gnt(input int k, input bit p);
    if (k == 1) return bus3.gnt0;
    return p ? bus.gnt1 : bus.gnt0;
  endfunction

  function automatic logic g_rv(input int k, input bit p);
    if (k == 1) return bus3.rvalid0;
    return p ? bus.rvalid1 : bus.rvalid0;
  endfunction

  function automatic logic g_busy(input int k);
    return (k == 1) ? bus3.busy : bus.busy;
  endfunction

  function automatic logic [15:0] g_rdata(input int k);
    return (k == 1) ? bus3.rdata : bus.rdata;
  endfunction

  // One complete transaction; lat = cycles from gnt to rvalid (or busy low).
  task automatic xact(input int k, input bit p, input bit we,
                      input logic [17:0] a, input logic [15:0] d,
                      input logic [1:0] be,
                      output logic [15:0] rd, output int lat);
    int  g;
    bit  done;
    g = -1; done = 0; rd = 16'h0; lat = -1;
    clr();
    wd[k] = d; wr[k] = we;
    set_port(k, p, 1'b1, we, a, d, be);
    for (int i = 0; i < 20 && g < 0; i++) begin
      tick();
      if (g_gnt(k, p)) g = cyc;
    end
    set_port(k, p, 1'b0, we, a, d, be);
    if (g < 0) begin
      chk("gnt_timeout", 32'd0, 32'd1);
    end else begin
      for (int i = 0; i < 20 && !done; i++) begin
        tick();
        if (we ? !g_busy(k) : g_rv(k, p)) begin
          done = 1; lat = cyc - g; rd = g_rdata(k);
        end
      end
      if (!done) chk("done_timeout", 32'd0, 32'd1);
    end
    wr[k] = 1'b0;
  endtask

  // Both ports request reads together; returns grant cycles.
  task automatic pair(output int g0, output int g1);
    g0 = -1; g1 = -1;
    set_port(0, 0, 1'b1, 1'b0, 18'h10, 16'h0, 2'b11);
    set_port(0, 1, 1'b1, 1'b0, 18'h20, 16'h0, 2'b11);
    for (int i = 0; i < 40 && (g0 < 0 || g1 < 0); i++) begin
      tick();
      if (bus.gnt0 && g0 < 0) begin
        g0 = cyc; set_port(0, 0, 1'b0, 1'b0, 18'h10, 16'h0, 2'b11);
      end
      if (bus.gnt1 && g1 < 0) begin
        g1 = cyc; set_port(0, 1, 1'b0, 1'b0, 18'h20, 16'h0, 2'b11);
      end
    end
    if (g0 < 0 || g1 < 0) chk("pair_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 6; i++) tick();
  endtask

  logic [15:0] rd;
  int          lat;
  int          g0, g1;
  int          n_g, n_bad, prev;
  bit          off0;
  bit          seen_rv;

  initial begin
    rst = 1'b1;
    wr[0] = 1'b0; wr[1] = 1'b0; wd[0] = '0; wd[1] = '0;
    set_port(0, 0, 1'b0, 1'b0, '0, '0, 2'b00);
    set_port(0, 1, 1'b0, 1'b0, '0, '0, 2'b00);
    set_port(1, 0, 1'b0, 1'b0, '0, '0, 2'b00);
    bus3.req1 = 1'b0; bus3.we1 = 1'b0; bus3.addr1 = '0;
    bus3.wdata1 = '0; bus3.be1 = 2'b00;
    clr();
    for (int i = 0; i < 3; i++) tick();

    chk("rst_ce", ce_a, 1'b1);
    chk("rst_oe", oe_a, 1'b1);
    chk("rst_we", we_a, 1'b1);
    chk("rst_lanes", {ub_a, lb_a}, 2'b11);
    chk("rst_addr", addr_a, 18'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rdata", bus.rdata, 16'h0);
    chk("rst_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
    chk("rst_rvalid", {bus.rvalid1, bus.rvalid0}, 2'b00);
    chk("rst_ce_w3", ce_b, 1'b1);
    rst = 1'b0;
    tick();

    xact(0, 0, 1'b1, 18'h10, 16'hA5C3, 2'b11, rd, lat);
    chk("wr_len", lat, 4);
    chk("wr_we_lo", we_lo[0], 2);
    chk("wr_oe_lo", oe_lo[0], 0);
    chk("wr_busy", bsy_n[0], 4);
    chk("wr_dq_cycles", drv[0], 4);
    chk("wr_dq_idle", drv_x[0], 0);
    chk("wr_mem", mem_a[8'h10], 16'hA5C3);

    xact(0, 1, 1'b0, 18'h10, 16'h0, 2'b11, rd, lat);
    chk("rd1_lat", lat, 4);
    chk("rd1_data", rd, 16'hA5C3);
    chk("rd1_oe_lo", oe_lo[0], 3);
    chk("rd1_we_lo", we_lo[0], 0);

    xact(0, 0, 1'b1, 18'h20, 16'hFFFF, 2'b11, rd, lat);
    xact(0, 0, 1'b1, 18'h20, 16'h1234, 2'b01, rd, lat);
    xact(0, 1, 1'b0, 18'h20, 16'h0, 2'b00, rd, lat);
    chk("be01_data", rd, 16'hFF34);
    xact(0, 0, 1'b1, 18'h20, 16'hAAAA, 2'b00, rd, lat);
    chk("be00_len", lat, 4);
    chk("be00_we_lo", we_lo[0], 2);
    xact(0, 0, 1'b0, 18'h20, 16'h0, 2'b11, rd, lat);
    chk("be00_data", rd, 16'hFF34);

    xact(1, 0, 1'b1, 18'h30, 16'h5A5A, 2'b11, rd, lat);
    chk("w3_len", lat, 6);
    chk("w3_we_lo", we_lo[1], 4);
    chk("w3_busy", bsy_n[1], 6);
    chk("w3_dq_cycles", drv[1], 6);
    chk("w3_dq_idle", drv_x[1], 0);
    xact(1, 0, 1'b0, 18'h30, 16'h0, 2'b11, rd, lat);
    chk("w3_rd_lat", lat, 6);
    chk("w3_rd_data", rd, 16'h5A5A);
    chk("w3_oe_lo", oe_lo[1], 5);

    // Reset during ACCESS of a read.
    g0 = -1;
    set_port(0, 0, 1'b1, 1'b0, 18'h10, 16'h0, 2'b11);
    for (int i = 0; i < 10 && g0 < 0; i++) begin
      tick();
      if (bus.gnt0) g0 = cyc;
    end
    set_port(0, 0, 1'b0, 1'b0, 18'h10, 16'h0, 2'b11);
    chk("mid_gnt", g0 >= 0, 1'b1);
    tick();
    chk("mid_in_access", oe_a, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_ce", ce_a, 1'b1);
    chk("mid_oe", oe_a, 1'b1);
    chk("mid_we", we_a, 1'b1);
    chk("mid_busy", bus.busy, 1'b0);
    chk("mid_rdata", bus.rdata, 16'h0);
    seen_rv = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.rvalid0 || bus.rvalid1) seen_rv = 1;
    end
    chk("mid_no_rvalid", seen_rv, 1'b0);
    xact(0, 0, 1'b0, 18'h10, 16'h0, 2'b11, rd, lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_data", rd, 16'hA5C3);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pair(g0, g1);
    chk("tie_p0_first", g0 < g1, 1'b1);
    chk("tie_gap", g1 - g0, 5);
    pair(g0, g1);
    chk("tie3_p0_first", g0 < g1, 1'b1);

    // P1 holds req, P0 re-requests one cycle after each grant.
    n_g = 0; n_bad = 0; prev = -1; off0 = 0;
    set_port(0, 1, 1'b1, 1'b0, 18'h20, 16'h0, 2'b11);
    set_port(0, 0, 1'b1, 1'b0, 18'h10, 16'h0, 2'b11);
    for (int i = 0; i < 700 && n_g < 100; i++) begin
      tick();
      if (off0) begin
        set_port(0, 0, 1'b1, 1'b0, 18'h10, 16'h0, 2'b11);
        off0 = 0;
      end
      if (bus.gnt0 && bus.gnt1) n_bad++;
      if (bus.gnt0) begin
        if (prev == 0) n_bad++;
        prev = 0; n_g++; off0 = 1;
        set_port(0, 0, 1'b0, 1'b0, 18'h10, 16'h0, 2'b11);
      end else if (bus.gnt1) begin
        if (prev == 1) n_bad++;
        prev = 1; n_g++;
      end
    end
    set_port(0, 0, 1'b0, 1'b0, 18'h10, 16'h0, 2'b11);
    set_port(0, 1, 1'b0, 1'b0, 18'h20, 16'h0, 2'b11);
    chk("rr_count", n_g, 100);
    chk("rr_alternate", n_bad, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("rr_drained", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
